// File: rtl/matrix_scan_driver.sv
`default_nettype none
// +-----------------------------------------------------------------------------+
// | matrix_scan_driver                                                          |
// | Captures a 64-pixel serial frame into a back buffer, swaps it to the front  |
// | buffer at the scan-frame boundary, and row-scans an 8x8 LED matrix.         |
// | Optional: define SCAN_BLANK_EN to insert BLANK_CYCLES of blanking per row.  |
// | Revision: 1.0                                                               |
// +-----------------------------------------------------------------------------+
module matrix_scan_driver #(
  parameter int ROW_CYCLES   = 16,
  parameter int BLANK_CYCLES = 2
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       frame_sync,
  input  logic [3:0] pixel_data,
  output logic [7:0] row_sel,
  output logic [7:0] col_data,
  output logic       capture_busy,
  output logic       frame_done,
  output logic       frame_err,
  output logic       overrun
);

  localparam int c_MAX_CYC = (ROW_CYCLES > BLANK_CYCLES) ? ROW_CYCLES : BLANK_CYCLES;
  localparam int c_CNT_W   = (c_MAX_CYC > 1) ? $clog2(c_MAX_CYC) : 1;
  localparam logic [c_CNT_W-1:0] c_ROW_LAST = c_CNT_W'(ROW_CYCLES - 1);
`ifdef SCAN_BLANK_EN
  localparam logic [c_CNT_W-1:0] c_BLANK_LAST = c_CNT_W'(BLANK_CYCLES - 1);
`endif

  typedef enum logic [0:0] {C_IDLE = 1'b0, C_CAP = 1'b1} cap_state_t;
  typedef enum logic [0:0] {S_ROW = 1'b0, S_BLANK = 1'b1} scan_state_t;

  // Capture side
  cap_state_t       r_cap_state, w_cap_next;
  logic [5:0]       r_pix_cnt, w_pix_next;
  logic             r_capture_busy, w_busy_next;
  logic             r_frame_done, w_done_next;
  logic             r_frame_err, w_err_next;
  logic             w_set_pend;
  logic             w_wr_en;
  logic [7:0][7:0]  r_back;

  // Buffer hand-off
  logic [7:0][7:0]  r_front;
  logic             r_swap_pend;
  logic             r_overrun;

  // Scan side
  scan_state_t      r_scan_state, w_scan_next;
  logic [2:0]       r_row_cnt, w_row_next;
  logic [c_CNT_W-1:0] r_cyc_cnt, w_cyc_next;
  logic             w_wrap;
  logic [7:0]       r_row_sel;
  logic [7:0]       r_col_data;

  always_comb begin
    w_cap_next  = r_cap_state;
    w_pix_next  = r_pix_cnt;
    w_busy_next = r_capture_busy;
    w_done_next = 1'b0;
    w_err_next  = 1'b0;
    w_set_pend  = 1'b0;
    w_wr_en     = 1'b0;
    if (frame_sync) begin
      w_cap_next  = C_CAP;
      w_pix_next  = 6'd0;
      w_busy_next = 1'b1;
      w_err_next  = (r_cap_state == C_CAP);
    end else if (r_cap_state == C_CAP) begin
      w_wr_en    = 1'b1;
      w_pix_next = r_pix_cnt + 6'd1;
      if (r_pix_cnt == 6'd63) begin
        w_cap_next  = C_IDLE;
        w_busy_next = 1'b0;
        w_set_pend  = 1'b1;
        w_done_next = 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_cap_state    <= C_IDLE;
      r_pix_cnt      <= 6'd0;
      r_capture_busy <= 1'b0;
      r_frame_done   <= 1'b0;
      r_frame_err    <= 1'b0;
      r_back         <= '0;
    end else begin
      r_cap_state    <= w_cap_next;
      r_pix_cnt      <= w_pix_next;
      r_capture_busy <= w_busy_next;
      r_frame_done   <= w_done_next;
      r_frame_err    <= w_err_next;
      if (w_wr_en) begin
        r_back[r_pix_cnt[5:3]][r_pix_cnt[2:0]] <= |pixel_data;
      end
    end
  end

  // A freshly completed frame wins over a same-cycle wrap, so it waits for the next wrap.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_front     <= '0;
      r_swap_pend <= 1'b0;
      r_overrun   <= 1'b0;
    end else begin
      r_overrun <= 1'b0;
      if (w_wrap && r_swap_pend) begin
        r_front <= r_back;
      end
      if (w_set_pend) begin
        r_swap_pend <= 1'b1;
      end else if (w_wrap && r_swap_pend) begin
        r_swap_pend <= 1'b0;
      end else if (frame_sync && r_swap_pend) begin
        r_swap_pend <= 1'b0;
        r_overrun   <= 1'b1;
      end
    end
  end

  always_comb begin
    w_scan_next = r_scan_state;
    w_row_next  = r_row_cnt;
    w_cyc_next  = (r_cyc_cnt == {c_CNT_W{1'b1}}) ? r_cyc_cnt : r_cyc_cnt + c_CNT_W'(1);
    w_wrap      = 1'b0;
    case (r_scan_state)
      S_ROW: begin
        if (r_cyc_cnt == c_ROW_LAST) begin
          w_cyc_next = '0;
`ifdef SCAN_BLANK_EN
          w_scan_next = S_BLANK;
`else
          w_row_next = r_row_cnt + 3'd1;
          w_wrap     = (r_row_cnt == 3'd7);
`endif
        end
      end
      S_BLANK: begin
`ifdef SCAN_BLANK_EN
        if (r_cyc_cnt == c_BLANK_LAST) begin
          w_scan_next = S_ROW;
          w_cyc_next  = '0;
          w_row_next  = r_row_cnt + 3'd1;
          w_wrap      = (r_row_cnt == 3'd7);
        end
`else
        w_scan_next = S_ROW;
        w_cyc_next  = '0;
`endif
      end
      default: begin
        w_scan_next = S_ROW;
        w_cyc_next  = '0;
      end
    endcase
  end

  // Outputs lag the scan state by one clock, so row 0 after a wrap sees the new front.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_scan_state <= S_ROW;
      r_row_cnt    <= 3'd0;
      r_cyc_cnt    <= '0;
      r_row_sel    <= 8'h00;
      r_col_data   <= 8'h00;
    end else begin
      r_scan_state <= w_scan_next;
      r_row_cnt    <= w_row_next;
      r_cyc_cnt    <= w_cyc_next;
      r_row_sel    <= (r_scan_state == S_ROW) ? (8'h01 << r_row_cnt) : 8'h00;
      r_col_data   <= (r_scan_state == S_ROW) ? r_front[r_row_cnt] : 8'h00;
    end
  end

  assign row_sel      = r_row_sel;
  assign col_data     = r_col_data;
  assign capture_busy = r_capture_busy;
  assign frame_done   = r_frame_done;
  assign frame_err    = r_frame_err;
  assign overrun      = r_overrun;

endmodule
`default_nettype wire

// File: tb/tb_matrix_scan_driver.sv
`default_nettype none
// +-----------------------------------------------------------------------------+
// | tb_matrix_scan_driver                                                       |
// | Directed self-checking bench for matrix_scan_driver.                        |
// | Revision: 1.0                                                               |
// +-----------------------------------------------------------------------------+
module tb_matrix_scan_driver;

`ifdef SCAN_BLANK_EN
  localparam int c_PERIOD = 144;
`else
  localparam int c_PERIOD = 128;
`endif

  logic       clk = 1'b0;
  logic       rst;
  logic       frame_sync;
  logic [3:0] pixel_data;
  logic [7:0] row_sel;
  logic [7:0] col_data;
  logic       capture_busy;
  logic       frame_done;
  logic       frame_err;
  logic       overrun;

  int n_checks = 0;
  int n_fail   = 0;
  int tb_cyc   = 0;
  int done_cnt = 0, err_cnt = 0, ovr_cnt = 0;
  int done_cyc = 0, err_cyc = 0, ovr_cyc = 0;

  matrix_scan_driver #(.ROW_CYCLES(16), .BLANK_CYCLES(2)) dut (
    .clk          (clk),
    .rst          (rst),
    .frame_sync   (frame_sync),
    .pixel_data   (pixel_data),
    .row_sel      (row_sel),
    .col_data     (col_data),
    .capture_busy (capture_busy),
    .frame_done   (frame_done),
    .frame_err    (frame_err),
    .overrun      (overrun)
  );

  always #5 clk = ~clk;

  always @(posedge clk) tb_cyc <= tb_cyc + 1;

  always @(negedge clk) begin
    if (frame_done) begin done_cnt <= done_cnt + 1; done_cyc <= tb_cyc; end
    if (frame_err)  begin err_cnt  <= err_cnt + 1;  err_cyc  <= tb_cyc; end
    if (overrun)    begin ovr_cnt  <= ovr_cnt + 1;  ovr_cyc  <= tb_cyc; end
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [3:0] pix(input int pat, input int k);
    case (pat)
      0:       return (k == 9) ? 4'h1 : 4'h0;
      1:       return 4'hF;
      3:       return ((k / 8) == (k % 8)) ? 4'h8 : 4'h0;
      4:       return ((k % 8) == (7 - k / 8)) ? 4'h2 : 4'h0;
      default: return 4'h0;
    endcase
  endfunction

  function automatic logic [7:0] exp_row(input int pat, input int r);
    case (pat)
      0:       return (r == 1) ? 8'h02 : 8'h00;
      1:       return 8'hFF;
      3:       return 8'h01 << r;
      4:       return 8'h80 >> r;
      default: return 8'h00;
    endcase
  endfunction

  task automatic send_sync(output int sc);
    frame_sync = 1'b1;
    sc = tb_cyc;
    tick();
    frame_sync = 1'b0;
  endtask

  task automatic send_pixels(input int pat, input int from, input int to);
    for (int k = from; k < to; k++) begin
      pixel_data = pix(pat, k);
      tick();
    end
    pixel_data = 4'h0;
  endtask

  task automatic wait_row(input int r);
    logic [7:0] want;
    want = 8'h01 << r;
    for (int i = 0; i < 400 && row_sel != want; i++) tick();
    if (row_sel != want) check("wait_row_timeout", row_sel, want);
  endtask

  task automatic check_frame(input int pat, input bit after_wrap, input string tag);
    if (after_wrap) begin
      wait_row(7);
      wait_row(0);
    end
    for (int r = 0; r < 8; r++) begin
      wait_row(r);
      check($sformatf("%s_r%0d", tag, r), col_data, exp_row(pat, r));
    end
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: got=timeout exp=finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int c0, sc, sc2, d0, e0, o0;
    rst = 1'b1; frame_sync = 1'b0; pixel_data = 4'h0;
    repeat (3) tick();

    // T1: reset values, first rows, scan period
    check("t1_rst_row_sel", row_sel, 8'h00);
    check("t1_rst_col_data", col_data, 8'h00);
    check("t1_rst_busy", capture_busy, 1'b0);
    check("t1_rst_done", frame_done, 1'b0);
    check("t1_rst_err", frame_err, 1'b0);
    check("t1_rst_overrun", overrun, 1'b0);
    rst = 1'b0;
    tick();
    c0 = tb_cyc;
    check("t1_row0_first", row_sel, 8'h01);
    repeat (15) tick();
    check("t1_row0_last", row_sel, 8'h01);
    tick();
`ifdef SCAN_BLANK_EN
    check("t1_blank0", row_sel, 8'h00);
    tick();
    check("t1_blank1", row_sel, 8'h00);
    tick();
`endif
    check("t1_row1", row_sel, 8'h02);
    for (int i = 0; i < 400 && row_sel != 8'h01; i++) tick();
    check("t1_period", tb_cyc - c0, c_PERIOD);

    // T2: single lit pixel 9
    d0 = done_cnt;
    send_sync(sc);
    send_pixels(0, 0, 32);
    check("t2_busy", capture_busy, 1'b1);
    send_pixels(0, 32, 64);
    tick();
    check("t2_done_cnt", done_cnt - d0, 1);
    check("t2_done_time", done_cyc - sc, 65);
    check("t2_busy_end", capture_busy, 1'b0);
    check_frame(0, 1'b1, "t2");

    // T3: resync mid-capture discards the partial frame
    d0 = done_cnt; e0 = err_cnt; o0 = ovr_cnt;
    send_sync(sc);
    send_pixels(1, 0, 30);
    send_sync(sc2);
    send_pixels(3, 0, 64);
    tick();
    check("t3_err_cnt", err_cnt - e0, 1);
    check("t3_err_time", err_cyc - sc2, 1);
    check("t3_done_cnt", done_cnt - d0, 1);
    check("t3_done_time", done_cyc - sc2, 65);
    check("t3_ovr_cnt", ovr_cnt - o0, 0);
    check_frame(3, 1'b1, "t3");

    // T3b: sync coincident with pixel 63 wins
    d0 = done_cnt; e0 = err_cnt;
    send_sync(sc);
    send_pixels(1, 0, 63);
    pixel_data = 4'hF;
    send_sync(sc2);
    pixel_data = 4'h0;
    send_pixels(4, 0, 64);
    tick();
    check("t3b_err_cnt", err_cnt - e0, 1);
    check("t3b_done_cnt", done_cnt - d0, 1);
    check("t3b_done_time", done_cyc - sc2, 65);
    check_frame(4, 1'b1, "t3b");

    // T4: two frames before a wrap -> overrun, second frame displayed
    wait_row(0);
    d0 = done_cnt; o0 = ovr_cnt;
    send_sync(sc);
    send_pixels(1, 0, 64);
    send_sync(sc2);
    send_pixels(2, 0, 64);
    tick();
    check("t4_ovr_cnt", ovr_cnt - o0, 1);
    check("t4_ovr_time", ovr_cyc - sc2, 1);
    check("t4_done_cnt", done_cnt - d0, 2);
    check_frame(2, 1'b1, "t4");

    // T5: reset in the middle of a capture
    d0 = done_cnt;
    send_sync(sc);
    send_pixels(1, 0, 40);
    pixel_data = 4'hF;
    rst = 1'b1;
    tick();
    tick();
    check("t5_busy", capture_busy, 1'b0);
    check("t5_row_sel", row_sel, 8'h00);
    check("t5_col_data", col_data, 8'h00);
    rst = 1'b0;
    pixel_data = 4'h0;
    tick();
    check("t5_row0_first", row_sel, 8'h01);
    check_frame(2, 1'b0, "t5a");
    check_frame(2, 1'b1, "t5b");
    check("t5_no_done", done_cnt - d0, 0);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
